// File: rtl/dot_seq_ctrl_if.sv
// Operand, array and result bundle for the dot-product sequencer.
// The design instantiating this is configured by DOT_SEQ_ACC_SATURATE_EN.
interface dot_seq_ctrl_if #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int LEN_W     = 8,
  parameter int ACC_SIZE  = 32
);
  localparam int PW = IN_SIZE_0 + IN_SIZE_1 + 4;

  logic                          start_i;
  logic [LEN_W-1:0]              len_i;
  logic                          busy_o;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [7:0][IN_SIZE_0-1:0]     in_0_i;
  logic [7:0][IN_SIZE_1-1:0]     in_1_i;
  logic [7:0][IN_SIZE_0-1:0]     arr_in_0_o;
  logic [7:0][IN_SIZE_1-1:0]     arr_in_1_o;
  logic [1:0][PW-1:0]            arr_out_i;
  logic                          res_valid_o;
  logic                          res_ready_i;
  logic [ACC_SIZE-1:0]           res_o;

  modport master (
    output start_i, len_i,
    output in_valid_i, in_0_i, in_1_i,
    output arr_out_i, res_ready_i,
    input  busy_o, in_ready_o,
    input  arr_in_0_o, arr_in_1_o,
    input  res_valid_o, res_o
  );

  modport slave (
    input  start_i, len_i,
    input  in_valid_i, in_0_i, in_1_i,
    input  arr_out_i, res_ready_i,
    output busy_o, in_ready_o,
    output arr_in_0_o, arr_in_1_o,
    output res_valid_o, res_o
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Sequencer for the 8-lane signed multiply/compress array.
// Define DOT_SEQ_ACC_SATURATE_EN for a saturating accumulator.
module dot_seq_ctrl #(
  parameter int IN_SIZE_0     = 4,
  parameter int IN_SIZE_1     = 8,
  parameter int LEN_W         = 8,
  parameter int ACC_SIZE      = 32,
  parameter int ARRAY_LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dot_seq_ctrl_if.slave bus
);
  localparam int PW = IN_SIZE_0 + IN_SIZE_1 + 4;
  localparam int AL = ARRAY_LATENCY;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t                     state_q;
  logic [LEN_W-1:0]           cnt_q;
  logic [AL-1:0]              fly_q;
  logic [AL-1:0]              fly_sh;
  logic signed [ACC_SIZE-1:0] acc_q;
  logic signed [ACC_SIZE-1:0] res_q;
  logic signed [ACC_SIZE-1:0] acc_sum;
  logic signed [ACC_SIZE-1:0] acc_upd;
  logic signed [ACC_SIZE-1:0] chunk_ext;
  logic [PW-1:0]              chunk;
  logic                       busy_q;
  logic                       rdy_q;
  logic                       vld_q;
  logic                       accept;
  logic                       tap;
  logic                       drained;
  logic                       st_idle;
  logic                       st_feed;
  logic                       st_drain;
  logic                       st_done;

  assign st_idle  = (state_q == IDLE);
  assign st_feed  = (state_q == FEED);
  assign st_drain = (state_q == DRAIN);
  assign st_done  = (state_q == DONE);

  assign accept = rdy_q & bus.in_valid_i;
  assign tap    = fly_q[AL-1];
  assign fly_sh = fly_q << 1;
  // Only the tap may still be set: this is the last array result.
  assign drained = (fly_sh == '0);

  assign bus.arr_in_0_o = accept ? bus.in_0_i : '0;
  assign bus.arr_in_1_o = accept ? bus.in_1_i : '0;

  assign chunk = bus.arr_out_i[0] + bus.arr_out_i[1];
  assign chunk_ext = ACC_SIZE'($signed(chunk));

`ifdef DOT_SEQ_ACC_SATURATE_EN
  localparam logic signed [ACC_SIZE-1:0] ACC_MAX =
    {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] ACC_MIN =
    {1'b1, {(ACC_SIZE-1){1'b0}}};

  logic signed [ACC_SIZE:0] wide;

  always_comb begin
    wide = $signed({acc_q[ACC_SIZE-1], acc_q})
         + $signed({chunk_ext[ACC_SIZE-1], chunk_ext});
    acc_sum = wide[ACC_SIZE-1:0];
    if (wide[ACC_SIZE] != wide[ACC_SIZE-1]) begin
      acc_sum = wide[ACC_SIZE] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign acc_sum = acc_q + chunk_ext;
`endif

  assign acc_upd = tap ? acc_sum : acc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fly_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      fly_q <= fly_sh | AL'(accept);
      acc_q <= acc_upd;
      unique case (1'b1)
        st_idle: begin
          if (bus.start_i) begin
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (bus.len_i != '0) begin
              cnt_q   <= bus.len_i;
              rdy_q   <= 1'b1;
              state_q <= FEED;
            end else begin
              res_q   <= '0;
              vld_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        st_feed: begin
          if (accept) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              rdy_q   <= 1'b0;
              state_q <= DRAIN;
            end
          end
        end
        st_drain: begin
          if (drained) begin
            res_q   <= acc_upd;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        st_done: begin
          if (bus.res_ready_i) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.in_ready_o  = rdy_q;
  assign bus.res_valid_o = vld_q;
  assign bus.res_o       = res_q;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Scoreboard bench for dot_seq_ctrl with a behavioural array model.
// Expected results come from plain dot-product arithmetic.
module tb_dot_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  logic rand_mode = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_rdy = 1'b1;

  logic [31:0] exp_q[$];
  logic [15:0] q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  dot_seq_ctrl_if #(.ACC_SIZE(32)) if0 ();
  dot_seq_ctrl_if #(.ACC_SIZE(16)) if16 ();

  dot_seq_ctrl #(.ACC_SIZE(32)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );

  dot_seq_ctrl #(.ACC_SIZE(16)) u_dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if16.slave)
  );

  assign if0.res_ready_i  = rand_mode ? rnd_rdy : ready_force;
  assign if16.res_ready_i = 1'b1;

  function automatic logic [15:0] psum(
    input logic [7:0][3:0] a,
    input logic [7:0][7:0] b
  );
    int s = 0;
    for (int i = 0; i < 8; i++)
      s = s + int'($signed(a[i])) * int'($signed(b[i]));
    return s[15:0];
  endfunction

  // Array model: 2 registered stages, random carry-save split.
  logic [15:0] s1a, w0a, w1a, rnda;
  logic [15:0] s1b, w0b, w1b, rndb;
  always @(posedge clk) begin
    rnda <= 16'($urandom);
    rndb <= 16'($urandom);
    s1a  <= psum(if0.arr_in_0_o, if0.arr_in_1_o);
    s1b  <= psum(if16.arr_in_0_o, if16.arr_in_1_o);
    w0a  <= rnda;
    w1a  <= s1a - rnda;
    w0b  <= rndb;
    w1b  <= s1b - rndb;
  end
  assign if0.arr_out_i  = {w1a, w0a};
  assign if16.arr_out_i = {w1b, w0b};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && if0.res_valid_o && if0.res_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_res: got %0h want none", if0.res_o);
      end else begin
        chk("res", 64'(if0.res_o), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if16.res_valid_o && if16.res_ready_i) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_res16: got %0h want none", if16.res_o);
      end else begin
        chk("res16", 64'(if16.res_o), 64'(q16.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic acc;
      acc = if0.in_valid_i && if0.in_ready_o;
      chk("arr_in_0", 64'(if0.arr_in_0_o), acc ? 64'(if0.in_0_i) : 64'd0);
      chk("arr_in_1", 64'(if0.arr_in_1_o), acc ? 64'(if0.in_1_i) : 64'd0);
    end
  end

  function automatic logic [15:0] ref16(input int n, input int c);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + c;
`ifdef DOT_SEQ_ACC_SATURATE_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
`endif
    end
    return acc[15:0];
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (if0.busy_o && w < 300) begin
      step();
      w++;
    end
    chk("idle_wait", 64'(if0.busy_o), 64'd0);
  endtask

  task automatic feed_beat(input logic [7:0][3:0] a,
                           input logic [7:0][7:0] b);
    int w = 0;
    if0.in_valid_i = 1'b1;
    if0.in_0_i = a;
    if0.in_1_i = b;
    while (!if0.in_ready_o && w < 50) begin
      step();
      w++;
    end
    if (!if0.in_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got ready 0 want 1");
    end
    last_acc = cyc;
    step();
    if0.in_valid_i = 1'b0;
  endtask

  // mode 0 random, 1 A=1/B=1, 2 A=-8/B=-128 gapped, 3 A=1/B=2
  task automatic send_cmd(input int len, input int mode,
                          input bit poke, input bit push);
    logic [7:0][3:0] a;
    logic [7:0][7:0] b;
    longint tot = 0;
    int gaps;
    wait_idle();
    if0.start_i = 1'b1;
    if0.len_i = 8'(len);
    step();
    if0.start_i = 1'b0;
    for (int k = 0; k < len; k++) begin
      gaps = (mode == 0) ? $urandom_range(0, 2) :
             (mode == 2 && k > 0) ? 1 : 0;
      for (int g = 0; g < gaps; g++) begin
        if0.in_valid_i = 1'b0;
        if0.in_0_i = 32'($urandom);
        if0.in_1_i = {$urandom, $urandom};
        step();
      end
      if (poke && k == 1) begin
        if0.start_i = 1'b1;
        if0.len_i = 8'(len + 7);
        step();
        if0.start_i = 1'b0;
      end
      unique case (mode)
        1: begin a = {8{4'h1}}; b = {8{8'h01}}; end
        2: begin a = {8{4'h8}}; b = {8{8'h80}}; end
        3: begin a = {8{4'h1}}; b = {8{8'h02}}; end
        default: begin a = 32'($urandom); b = {$urandom, $urandom}; end
      endcase
      for (int i = 0; i < 8; i++)
        tot += longint'($signed(a[i])) * longint'($signed(b[i]));
      feed_beat(a, b);
    end
    if (push) exp_q.push_back(tot[31:0]);
  endtask

  initial begin
    int w;
    if0.start_i = 0; if0.len_i = 0; if0.in_valid_i = 0;
    if0.in_0_i = '0; if0.in_1_i = '0;
    if16.start_i = 0; if16.len_i = 0; if16.in_valid_i = 0;
    if16.in_0_i = '0; if16.in_1_i = '0;
    repeat (3) step();
    chk("rst_busy", 64'(if0.busy_o), 64'd0);
    chk("rst_ready", 64'(if0.in_ready_o), 64'd0);
    chk("rst_valid", 64'(if0.res_valid_o), 64'd0);
    chk("rst_res", 64'(if0.res_o), 64'd0);
    rst = 1'b0;
    step();

    // single beat, latency and busy drop
    send_cmd(1, 1, 0, 1);
    w = 0;
    while (!if0.res_valid_o && w < 20) begin
      step();
      w++;
    end
    chk("latency", 64'(cyc - last_acc), 64'd3);
    step();
    chk("busy_after", 64'(if0.busy_o), 64'd0);

    send_cmd(3, 2, 0, 1);
    send_cmd(3, 0, 1, 1);

    // zero-length command with result backpressure
    wait_idle();
    ready_force = 1'b0;
    if0.start_i = 1'b1;
    if0.len_i = 8'd0;
    step();
    if0.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("len0_valid", 64'(if0.res_valid_o), 64'd1);
      chk("len0_res", 64'(if0.res_o), 64'd0);
      step();
    end
    exp_q.push_back(32'd0);
    ready_force = 1'b1;
    step();
    step();

    // abort mid-feed with reset
    wait_idle();
    if0.start_i = 1'b1;
    if0.len_i = 8'd4;
    step();
    if0.start_i = 1'b0;
    feed_beat({8{4'h7}}, {8{8'h7f}});
    feed_beat({8{4'h7}}, {8{8'h7f}});
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("abort_busy", 64'(if0.busy_o), 64'd0);
    chk("abort_valid", 64'(if0.res_valid_o), 64'd0);
    send_cmd(1, 3, 0, 1);

    // 16-bit accumulator overflow
    q16.push_back(ref16(4, 8 * (-8) * (-128)));
    if16.start_i = 1'b1;
    if16.len_i = 8'd4;
    step();
    if16.start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      if16.in_valid_i = 1'b1;
      if16.in_0_i = {8{4'h8}};
      if16.in_1_i = {8{8'h80}};
      while (!if16.in_ready_o && w < 50) begin
        step();
        w++;
      end
      chk("beat16_ready", 64'(if16.in_ready_o), 64'd1);
      step();
    end
    if16.in_valid_i = 1'b0;

    // randomized commands with random result backpressure
    wait_idle();
    rand_mode = 1'b1;
    for (int n = 0; n < 10; n++)
      send_cmd($urandom_range(1, 6), 0, 0, 1);

    w = 0;
    while ((exp_q.size() != 0 || q16.size() != 0) && w < 500) begin
      step();
      w++;
    end
    chk("sb_drain", 64'(exp_q.size() + q16.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
